// File: rtl/avalon_mm_arb_master.sv
// rtl/avalon_mm_arb_master.sv - N-channel round-robin Avalon-MM master with lock hold and wait timeout
module avalon_mm_arb_master #(
  parameter int NCH    = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NCH-1:0]        ch_start,
  input  logic [NCH-1:0]        ch_rnw,
  input  logic [NCH-1:0]        ch_lock,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  input  logic [NCH*DATA_W-1:0] ch_wdata,
  output logic [NCH-1:0]        ch_busy,
  output logic [NCH-1:0]        ch_done,
  output logic [NCH-1:0]        ch_err,
  output logic [DATA_W-1:0]     ch_rdata,
  output logic [ADDR_W-1:0]     ADDRESS,
  output logic                  BEGINTRANSFER,
  output logic                  READ,
  output logic                  WRITE,
  output logic [DATA_W-1:0]     WRITEDATA,
  output logic                  LOCK,
  input  logic [DATA_W-1:0]     READDATA,
  input  logic                  WAITREQUEST
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W:0]   NCH_L    = (IDX_W+1)'(NCH);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NCH - 1);
  // Abort on the wait cycle that would bring the counter to all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state, state_d;

  // Per-channel request slots
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    slot_rnw;
  logic [NCH-1:0]    slot_lock;
  logic [ADDR_W-1:0] slot_addr  [NCH];
  logic [DATA_W-1:0] slot_wdata [NCH];

  // Transfer bookkeeping
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              lock_hold;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              first;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  // Decisions from the next-state logic
  logic [NCH-1:0]    cap;
  logic              rr_found;
  logic [IDX_W-1:0]  rr_pick;
  logic [IDX_W:0]    rr_sum;
  logic              own_req;
  logic              do_grant;
  logic [IDX_W-1:0]  grant_sel;
  logic [IDX_W-1:0]  rr_next;
  logic              xfer_ok;
  logic              xfer_tmo;
  logic              release_lock;

  // A start is accepted only when the channel has nothing outstanding
  always_comb begin
    cap = ch_start & ~pend;
  end

  // Round-robin search: first pending channel at or after rr_ptr, wrapping
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_sum   = '0;
    for (int k = 0; k < NCH; k++) begin
      rr_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (rr_sum >= NCH_L) begin
        rr_sum = rr_sum - NCH_L;
      end
      if (!rr_found && pend[rr_sum[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_sum[IDX_W-1:0];
      end
    end
  end

  // The lock owner's re-request can only arrive in the IDLE cycle after its done
  // (a start during RESP is ignored), so a start pulse there counts as pending.
  always_comb begin
    own_req = lock_hold && (pend[owner] || ch_start[owner]);
  end

  // Next-state and control decisions
  always_comb begin
    state_d      = state;
    do_grant     = 1'b0;
    grant_sel    = rr_pick;
    xfer_ok      = 1'b0;
    xfer_tmo     = 1'b0;
    release_lock = 1'b0;
    case (state)
      ST_IDLE: begin
        if (own_req) begin
          do_grant  = 1'b1;
          grant_sel = owner;
          state_d   = ST_XFER;
        end else begin
          release_lock = lock_hold;
          if (rr_found) begin
            do_grant = 1'b1;
            state_d  = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (!WAITREQUEST) begin
          xfer_ok = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          xfer_tmo = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rr_next = (grant_sel == LAST_CH) ? '0 : grant_sel + 1'b1;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Request slots, arbitration pointer, timeout counter and response capture
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend      <= '0;
      slot_rnw  <= '0;
      slot_lock <= '0;
      for (int i = 0; i < NCH; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
      grant     <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_hold <= 1'b0;
      tmo_cnt   <= '0;
      first     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cap[i]) begin
          pend[i]       <= 1'b1;
          slot_rnw[i]   <= ch_rnw[i];
          slot_lock[i]  <= ch_lock[i];
          slot_addr[i]  <= ch_addr[i*ADDR_W +: ADDR_W];
          slot_wdata[i] <= ch_wdata[i*DATA_W +: DATA_W];
        end
      end
      case (state)
        ST_IDLE: begin
          if (release_lock) begin
            lock_hold <= 1'b0;
          end
          if (do_grant) begin
            grant   <= grant_sel;
            rr_ptr  <= rr_next;
            tmo_cnt <= '0;
            first   <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        ST_XFER: begin
          first <= 1'b0;
          if (xfer_ok) begin
            rdata_q <= READDATA;
          end else if (xfer_tmo) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          pend[grant] <= 1'b0;
          lock_hold   <= slot_lock[grant] & ~err_q;
          owner       <= grant;
        end
        default: begin
        end
      endcase
    end
  end

  // Bus and requester outputs decoded from registered state
  always_comb begin
    ADDRESS       = '0;
    WRITEDATA     = '0;
    READ          = 1'b0;
    WRITE         = 1'b0;
    LOCK          = 1'b0;
    BEGINTRANSFER = 1'b0;
    ch_done       = '0;
    ch_err        = '0;
    ch_rdata      = '0;
    ch_busy       = pend;
    if (state == ST_XFER) begin
      ADDRESS       = slot_addr[grant];
      WRITEDATA     = slot_wdata[grant];
      READ          = slot_rnw[grant];
      WRITE         = ~slot_rnw[grant];
      LOCK          = slot_lock[grant];
      BEGINTRANSFER = first;
    end
    if (state == ST_RESP) begin
      ch_done = NCH'(1) << grant;
      ch_err  = err_q ? (NCH'(1) << grant) : '0;
      if (slot_rnw[grant] && !err_q) begin
        ch_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_arb_master.sv
// tb/tb_avalon_mm_arb_master.sv - directed self-checking bench for avalon_mm_arb_master
module tb_avalon_mm_arb_master;

  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [NCH-1:0]  ch_start, ch_rnw, ch_lock;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]  ch_busy, ch_done, ch_err;
  logic [DW-1:0]   ch_rdata;
  logic [AW-1:0]   ADDRESS;
  logic            BEGINTRANSFER, READ, WRITE, LOCK;
  logic [DW-1:0]   WRITEDATA;
  logic [DW-1:0]   READDATA;
  logic            WAITREQUEST;

  int checks = 0;
  int failures = 0;

  avalon_mm_arb_master #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .TMO_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ch_start(ch_start), .ch_rnw(ch_rnw), .ch_lock(ch_lock),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .ADDRESS(ADDRESS), .BEGINTRANSFER(BEGINTRANSFER), .READ(READ), .WRITE(WRITE),
    .WRITEDATA(WRITEDATA), .LOCK(LOCK), .READDATA(READDATA), .WAITREQUEST(WAITREQUEST)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    RST_N = 1'b0; ch_start = '0; ch_rnw = '0; ch_lock = '0;
    ch_addr = '0; ch_wdata = '0; READDATA = '0; WAITREQUEST = 1'b0;
    tick; tick;
    RST_N = 1'b1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; ch_start = 3'b111; ch_rnw = 3'b101; ch_lock = '0;
    ch_addr = {32'h3, 32'h2, 32'h1}; ch_wdata = '0; READDATA = '0; WAITREQUEST = 1'b0;
    tick; tick;
    checks++; if ({READ, WRITE, BEGINTRANSFER, LOCK} !== 4'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {READ, WRITE, BEGINTRANSFER, LOCK}); end
    checks++; if (ch_busy !== 3'b000) begin failures++; $display("FAIL rst_busy got=%b exp=000", ch_busy); end
    checks++; if ({ch_done, ch_err} !== 6'b0) begin failures++; $display("FAIL rst_done_err got=%b exp=000000", {ch_done, ch_err}); end
    checks++; if ({ADDRESS, WRITEDATA, ch_rdata} !== 96'b0) begin failures++; $display("FAIL rst_data got=%h exp=0", {ADDRESS, WRITEDATA, ch_rdata}); end
    ch_start = '0;
    RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if ({READ, WRITE, ch_busy} !== 5'b0) begin failures++; $display("FAIL rst_idle_c%0d got=%b exp=00000", c, {READ, WRITE, ch_busy}); end
    end
  endtask

  task automatic test_single_read;
    apply_reset;
    WAITREQUEST = 1'b0; READDATA = 32'hCAFEF00D;
    ch_addr = {32'h0, 32'h100, 32'h0}; ch_rnw = 3'b010; ch_start = 3'b010;
    tick;  // edge k
    ch_start = '0;
    checks++; if (ch_busy !== 3'b010 || READ !== 1'b0) begin failures++; $display("FAIL rd_k busy=%b read=%b exp busy=010 read=0", ch_busy, READ); end
    tick;  // edge k+1
    checks++; if ({READ, WRITE, BEGINTRANSFER} !== 3'b101) begin failures++; $display("FAIL rd_strobe got=%b exp=101", {READ, WRITE, BEGINTRANSFER}); end
    checks++; if (ADDRESS !== 32'h100) begin failures++; $display("FAIL rd_addr got=%h exp=00000100", ADDRESS); end
    tick;  // edge k+2
    checks++; if (ch_done !== 3'b010 || ch_err !== 3'b000) begin failures++; $display("FAIL rd_done got=%b err=%b exp=010/000", ch_done, ch_err); end
    checks++; if (ch_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_rdata got=%h exp=cafef00d", ch_rdata); end
    checks++; if (READ !== 1'b0) begin failures++; $display("FAIL rd_drop got=%b exp=0", READ); end
    tick;
    checks++; if (ch_done !== 3'b000 || ch_busy !== 3'b000) begin failures++; $display("FAIL rd_after done=%b busy=%b exp=000/000", ch_done, ch_busy); end
  endtask

  task automatic test_round_robin_writes;
    logic [AW-1:0] exp_addr [3];
    logic [DW-1:0] exp_wd [3];
    logic [AW-1:0] seen_addr [3];
    logic [2:0]    done_seen [3];
    int hold [3];
    int n_begin, n_done, wd_bad;
    exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h30;
    exp_wd[0] = 32'hAAAA0001; exp_wd[1] = 32'hBBBB0002; exp_wd[2] = 32'hCCCC0003;
    for (int i = 0; i < 3; i++) begin
      hold[i] = 0; seen_addr[i] = '0; done_seen[i] = '0;
    end
    n_begin = 0; n_done = 0; wd_bad = 0;
    apply_reset;
    ch_rnw = 3'b000; ch_lock = 3'b000;
    ch_addr = {32'h30, 32'h20, 32'h10};
    ch_wdata = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    ch_start = 3'b111;
    tick;
    ch_start = '0;
    for (int c = 0; c < 25; c++) begin
      tick;
      if (BEGINTRANSFER) begin
        if (n_begin < 3) seen_addr[n_begin] = ADDRESS;
        n_begin++;
      end
      if (WRITE && n_begin >= 1 && n_begin <= 3) begin
        hold[n_begin-1]++;
        if (WRITEDATA !== exp_wd[n_begin-1] || ADDRESS !== seen_addr[n_begin-1]) wd_bad++;
      end
      WAITREQUEST = WRITE && n_begin >= 1 && n_begin <= 3 && hold[(n_begin >= 1 && n_begin <= 3) ? n_begin-1 : 0] < 3;
      if (ch_done !== 3'b000) begin
        if (n_done < 3) done_seen[n_done] = ch_done;
        n_done++;
      end
    end
    WAITREQUEST = 1'b0;
    checks++; if (n_begin !== 3) begin failures++; $display("FAIL rr_begins got=%0d exp=3", n_begin); end
    checks++; if (n_done !== 3) begin failures++; $display("FAIL rr_dones got=%0d exp=3", n_done); end
    checks++; if (wd_bad !== 0) begin failures++; $display("FAIL rr_stable got=%0d unstable cycles exp=0", wd_bad); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (seen_addr[i] !== exp_addr[i]) begin failures++; $display("FAIL rr_order%0d got=%h exp=%h", i, seen_addr[i], exp_addr[i]); end
      checks++; if (hold[i] !== 3) begin failures++; $display("FAIL rr_hold%0d got=%0d exp=3", i, hold[i]); end
      checks++; if (done_seen[i] !== (3'b001 << i)) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", i, done_seen[i], 3'b001 << i); end
    end
  endtask

  task automatic test_lock;
    apply_reset;
    WAITREQUEST = 1'b0;
    ch_rnw = 3'b000;
    ch_addr = {32'h200, 32'h0, 32'h300}; ch_wdata = {32'h22, 32'h0, 32'h11};
    ch_lock = 3'b100; ch_start = 3'b100;
    tick;  // ch2 captured
    ch_start = 3'b001; ch_lock = 3'b000;
    tick;  // ch2 XFER, ch0 captured
    ch_start = '0;
    checks++; if (WRITE !== 1'b1 || ADDRESS !== 32'h200 || LOCK !== 1'b1) begin failures++; $display("FAIL lk_x1 wr=%b addr=%h lock=%b exp 1/200/1", WRITE, ADDRESS, LOCK); end
    tick;  // RESP
    checks++; if (ch_done !== 3'b100) begin failures++; $display("FAIL lk_d1 got=%b exp=100", ch_done); end
    tick;  // IDLE: ch2 re-requests with lock
    checks++; if (ch_busy !== 3'b001) begin failures++; $display("FAIL lk_busy got=%b exp=001", ch_busy); end
    ch_addr = {32'h204, 32'h0, 32'h300}; ch_lock = 3'b100; ch_start = 3'b100;
    tick;
    ch_start = '0;
    checks++; if (WRITE !== 1'b1 || ADDRESS !== 32'h204 || LOCK !== 1'b1) begin failures++; $display("FAIL lk_x2 wr=%b addr=%h lock=%b exp 1/204/1", WRITE, ADDRESS, LOCK); end
    tick;  // RESP
    checks++; if (ch_done !== 3'b100) begin failures++; $display("FAIL lk_d2 got=%b exp=100", ch_done); end
    tick;  // IDLE: ch2 re-requests without lock
    ch_addr = {32'h208, 32'h0, 32'h300}; ch_lock = 3'b000; ch_start = 3'b100;
    tick;
    ch_start = '0;
    checks++; if (WRITE !== 1'b1 || ADDRESS !== 32'h208 || LOCK !== 1'b0) begin failures++; $display("FAIL lk_x3 wr=%b addr=%h lock=%b exp 1/208/0", WRITE, ADDRESS, LOCK); end
    tick;  // RESP
    tick;  // IDLE
    tick;  // ch0 XFER
    checks++; if (WRITE !== 1'b1 || ADDRESS !== 32'h300 || WRITEDATA !== 32'h11) begin failures++; $display("FAIL lk_ch0 wr=%b addr=%h wd=%h exp 1/300/11", WRITE, ADDRESS, WRITEDATA); end
    tick;
    checks++; if (ch_done !== 3'b001) begin failures++; $display("FAIL lk_d0 got=%b exp=001", ch_done); end
  endtask

  task automatic test_timeout;
    int rd_cycles;
    logic seen;
    apply_reset;
    WAITREQUEST = 1'b1; READDATA = 32'h12345678;
    ch_rnw = 3'b001; ch_addr = {32'h0, 32'h0, 32'h400}; ch_start = 3'b001;
    tick;
    ch_start = '0;
    rd_cycles = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick;
      if (READ) rd_cycles++;
      if (ch_done !== 3'b000) begin
        seen = 1'b1;
        checks++; if (ch_done !== 3'b001 || ch_err !== 3'b001) begin failures++; $display("FAIL to_pulse done=%b err=%b exp=001/001", ch_done, ch_err); end
        checks++; if (ch_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", ch_rdata); end
        checks++; if (READ !== 1'b0) begin failures++; $display("FAIL to_drop got=%b exp=0", READ); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_done_seen got=0 exp=1"); end
    checks++; if (rd_cycles !== 15) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=15", rd_cycles); end
    WAITREQUEST = 1'b0;
  endtask

  task automatic test_busy_ignore;
    int n_begin, n_done;
    logic [AW-1:0] first_addr;
    apply_reset;
    WAITREQUEST = 1'b0;
    ch_rnw = 3'b000; ch_addr = {32'h0, 32'h0, 32'h500}; ch_wdata = {32'h0, 32'h0, 32'h55};
    ch_start = 3'b001;
    tick;  // edge k captured
    ch_addr = {32'h0, 32'h0, 32'h5FF};
    n_begin = 0; n_done = 0; first_addr = '0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (c == 2) ch_start = '0;  // start held through XFER and RESP edges
      if (BEGINTRANSFER) begin
        if (n_begin == 0) first_addr = ADDRESS;
        n_begin++;
      end
      if (ch_done !== 3'b000) n_done++;
    end
    checks++; if (n_begin !== 1) begin failures++; $display("FAIL bi_begins got=%0d exp=1", n_begin); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL bi_dones got=%0d exp=1", n_done); end
    checks++; if (first_addr !== 32'h500) begin failures++; $display("FAIL bi_addr got=%h exp=00000500", first_addr); end
    checks++; if (ch_busy !== 3'b000) begin failures++; $display("FAIL bi_busy got=%b exp=000", ch_busy); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin_writes;
    test_lock;
    test_timeout;
    test_busy_ignore;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
